// File: rtl/sound_event_counter_if.sv
// Bus bundle for sound_event_counter: control/activity inputs and per-channel count outputs.
interface sound_event_counter_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 2
);
    logic [2:0]                state;
    logic [CHANNELS-1:0]       ain;
    logic                      clr;
    logic                      wrap;
    logic [CHANNELS*CNT_W-1:0] cnt;
    logic [CHANNELS-1:0]       sat;
    logic [CHANNELS-1:0]       ovf;
    logic [CHANNELS-1:0]       evt;
    logic                      tick;

    modport master (output state, ain, clr, wrap, input cnt, sat, ovf, evt, tick);
    modport slave  (input state, ain, clr, wrap, output cnt, sat, ovf, evt, tick);
endinterface

// File: rtl/sound_event_counter.sv
// Multi-channel debounced sound event counter with divided-clock sampling,
// saturate/wrap counting and game-state forcing of all counts to full scale.
module sound_event_counter #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned CNT_W      = 2,
    parameter int unsigned DIV        = 50_000_000,
    parameter int unsigned DEB        = 1,
    parameter logic [7:0]  FORCE_MASK = 8'b0011_0010
) (
    input logic                  CLK,
    input logic                  ena,
    sound_event_counter_if.slave bus
);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned DEB_W = $clog2(DEB + 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [DEB_W-1:0] DEB_TARGET = DEB_W'(DEB);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {ARMED = 2'd0, QUAL = 2'd1, WAIT_LOW = 2'd2} fsm_t;

    logic [DIV_W-1:0]    div_q, div_d;
    logic                tick_q, tick_d;
    fsm_t                fsm_q  [CHANNELS];
    fsm_t                fsm_d  [CHANNELS];
    logic [DEB_W-1:0]    dcnt_q [CHANNELS];
    logic [DEB_W-1:0]    dcnt_d [CHANNELS];
    logic [CNT_W-1:0]    cnt_q  [CHANNELS];
    logic [CNT_W-1:0]    cnt_d  [CHANNELS];
    logic [CHANNELS-1:0] ovf_q, ovf_d, evt_q, evt_d, sat_q, sat_d, qual;
    logic                force_hit;

    // Free-running divider; tick is registered so it reads 0 during reset
    always_comb begin
        div_d     = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        tick_d    = (div_d == DIV_LAST);
        force_hit = tick_q & FORCE_MASK[bus.state];
    end

    // Per-channel debounce FSM and counter next-state; clr outranks force outranks event
    always_comb begin
        for (int i = 0; i < int'(CHANNELS); i++) begin
            fsm_d[i]  = fsm_q[i];
            dcnt_d[i] = dcnt_q[i];
            cnt_d[i]  = cnt_q[i];
            ovf_d[i]  = ovf_q[i];
            evt_d[i]  = 1'b0;
            qual[i]   = 1'b0;
            if (bus.clr) begin
                fsm_d[i]  = ARMED;
                dcnt_d[i] = '0;
                cnt_d[i]  = '0;
                ovf_d[i]  = 1'b0;
            end else if (tick_q) begin
                if (!bus.ain[i]) begin
                    fsm_d[i]  = ARMED;
                    dcnt_d[i] = '0;
                end else begin
                    case (fsm_q[i])
                        ARMED: begin
                            dcnt_d[i] = DEB_W'(1);
                            if (DEB == 1) begin
                                qual[i]  = 1'b1;
                                fsm_d[i] = WAIT_LOW;
                            end else begin
                                fsm_d[i] = QUAL;
                            end
                        end
                        QUAL: begin
                            dcnt_d[i] = dcnt_q[i] + DEB_W'(1);
                            if (dcnt_d[i] == DEB_TARGET) begin
                                qual[i]  = 1'b1;
                                fsm_d[i] = WAIT_LOW;
                            end
                        end
                        default: ;
                    endcase
                end
                if (force_hit) begin
                    cnt_d[i] = CNT_MAX;
                end else if (qual[i]) begin
                    if (cnt_q[i] != CNT_MAX) begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        evt_d[i] = 1'b1;
                    end else if (bus.wrap) begin
                        cnt_d[i] = '0;
                        ovf_d[i] = 1'b1;
                        evt_d[i] = 1'b1;
                    end
                end
            end
            sat_d[i] = (cnt_d[i] == CNT_MAX);
        end
    end

    always_ff @(posedge CLK or negedge ena) begin
        if (!ena) begin
            div_q  <= '0;
            tick_q <= 1'b0;
            ovf_q  <= '0;
            evt_q  <= '0;
            sat_q  <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                fsm_q[i]  <= ARMED;
                dcnt_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
            ovf_q  <= ovf_d;
            evt_q  <= evt_d;
            sat_q  <= sat_d;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                fsm_q[i]  <= fsm_d[i];
                dcnt_q[i] <= dcnt_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_cnt
        assign bus.cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    assign bus.sat  = sat_q;
    assign bus.ovf  = ovf_q;
    assign bus.evt  = evt_q;
    assign bus.tick = tick_q;
endmodule

// File: doc/sound_event_counter.md
# sound_event_counter

Multi-channel, parametrised successor to the single-channel sound pulse counter. Each channel samples its audio-activity line on a divided-clock tick, debounces rising activity, and counts qualified events into a saturating or wrapping counter. Game states in a programmable set force every counter to full scale. The block sits between the audio/mic front end and the display/scoring logic, which read the per-channel counts and flags.

## Interface
- CHANNELS, 4, number of independent input channels (≥1)
- CNT_W, 2, counter width per channel; MAX = 2^CNT_W − 1
- DIV, 50_000_000, CLK cycles per sampling tick (≥1; 1 = tick every cycle)
- DEB, 1, consecutive high ticks required to qualify an event (≥1)
- FORCE_MASK, 8'b0011_0010, bit s set ⇒ state value s forces counters to MAX (default: states 1, 4, 5)

- CLK  in  1  system clock, all logic on rising edge
- ena  in  1  asynchronous active-low reset
- state  in  3  current game state; compared against FORCE_MASK on each tick
- ain  in  CHANNELS  per-channel activity lines (1 = active), synchronous to CLK
- clr  in  1  synchronous clear of all counters and flags, any cycle
- wrap  in  1  0 = saturate at MAX, 1 = wrap MAX→0
- cnt  out  CHANNELS*CNT_W  packed counts, channel i at [i*CNT_W +: CNT_W]
- sat  out  CHANNELS  channel count == MAX (registered-value decode)
- ovf  out  CHANNELS  sticky: channel wrapped at least once
- evt  out  CHANNELS  one-CLK pulse in the cycle after a channel's count changes due to an event
- tick  out  1  one-CLK pulse marking the sampling instant

## Operation
- Divider: counter 0..DIV−1, increments every CLK, wraps to 0. tick = 1 in the cycle where the counter equals DIV−1. clr does not affect the divider.
- Per-channel FSM with states ARMED, QUAL, WAIT_LOW and a debounce counter dcnt of width ⌈log2(DEB+1)⌉. The FSM advances only on tick cycles.
  - Any state, ain=0 at tick → ARMED, dcnt=0.
  - ARMED, ain=1 → dcnt=1. If DEB=1, the event qualifies and the FSM goes to WAIT_LOW; otherwise it goes to QUAL.
  - QUAL, ain=1 → dcnt+1. When dcnt+1 == DEB, the event qualifies and the FSM goes to WAIT_LOW.
  - WAIT_LOW, ain=1 → the FSM holds. Exactly one event is counted per high interval.
- On a qualified event:
  - If cnt<MAX, cnt+1.
  - If cnt==MAX and wrap=0, cnt holds and no evt is raised.
  - If cnt==MAX and wrap=1, cnt=0, ovf sets and evt is raised.
- Force: on a tick where FORCE_MASK[state]=1, every channel's cnt = MAX. No evt is raised and ovf is unchanged. FSM transitions still apply, but a qualifying event does not increment.
- Priority within a cycle: ena low > clr > force > event.
- clr: every cnt=0, ovf=0, every FSM=ARMED, dcnt=0, evt=0. If clr coincides with a tick, the tick's sampling is discarded.
- wrap is sampled at the event tick; changing it has no retroactive effect.

## Timing
- Reset (ena=0, asynchronous): divider=0, cnt=0, ovf=0, evt=0, tick=0, all FSMs ARMED, dcnt=0. sat therefore reads 1 only if MAX==0, which is impossible; sat=0.
- First tick occurs DIV cycles after ena deasserts; the first tick is in cycle DIV−1 counting from 0.
- cnt, ovf, and sat update on the clock edge that ends the tick cycle. evt is high for the single following cycle.
- Event latency from ain rising is at most (DEB)·DIV + DIV cycles, depending on tick phase.
- A high pulse entirely between two ticks is not seen. A low gap between two ticks does not re-arm.
- ena asserted mid-debounce or mid-count returns everything to reset values immediately; partial debounce is lost.

## Test plan
- Basic count: DIV=4, DEB=1, wrap=0, three separate ain[0] high pulses each 8 cycles → cnt0 = 1, 2, 3, with one evt0 pulse per event. A 4th pulse leaves cnt0=3, sat0=1, and raises no evt.
- Wrap: wrap=1, cnt0=3, one more pulse → cnt0=0, ovf0=1, evt0 pulse. clr → ovf0=0.
- Debounce: DEB=3, DIV=2; ain[1] high for 2 ticks then low → cnt1 stays 0. Then high for 5 ticks → cnt1=1, incrementing on the 3rd high tick. A sustained high adds nothing further.
- Force: state=4 at a tick → all cnt=MAX, evt=0, ovf unchanged. Then state=2 and one pulse on ch2 with wrap=0 → cnt2 stays MAX.
- Priority/simultaneity: clr coinciding with a tick and a qualifying event on ch0 → cnt0=0 and no evt. Force coinciding with an event → cnt=MAX and no evt.
- Async reset: drop ena mid-QUAL with cnt0=2 → all outputs 0 within the same cycle. After release, the first tick occurs exactly DIV cycles later.
